// File: rtl/b02_bcd_tx.sv
// -----------------------------------------------------------------------------
// b02_bcd_tx : serial BCD digit transmitter
//
// Accepts 4-bit BCD digits over a valid/ready handshake into a small FIFO and
// serializes each digit MSB-first onto LINEA. FRAME is high for every bit
// cycle, DONE pulses for one cycle after the last bit, and CNT counts the
// digits sent (modulo 256). Non-BCD digits (10..15) complete the handshake,
// are dropped, and set the sticky ERR flag.
//
// Parameters:
//   DEPTH    FIFO entries (power of 2, 2..16)
//   GAP      idle cycles inserted after each digit (0..15)
//   IDLE_LVL LINEA level when no bit is being sent
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous active-low reset
//   DIN[3:0]   in   digit to send
//   DIN_VALID  in   DIN valid this cycle
//   DIN_READY  out  block can accept DIN (low while reset is asserted)
//   LINEA      out  registered serial data line
//   FRAME      out  registered, high during every bit cycle of a digit
//   BUSY       out  FIFO non-empty or FSM not idle
//   DONE       out  one-cycle pulse after the last bit of a digit
//   ERR        out  sticky, a non-BCD digit was rejected
//   CNT[7:0]   out  digits transmitted, wraps modulo 256
//
// Optional feature macro: B02_BCD_TX_PARITY_EN
//   When defined, each digit is followed by an odd-parity bit (inverted XOR of
//   the 4 data bits) as a 5th bit cycle; FRAME spans 5 cycles and DONE/CNT
//   update after the parity bit.
// -----------------------------------------------------------------------------
module b02_bcd_tx #(
    parameter int   DEPTH    = 4,
    parameter int   GAP      = 1,
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] DIN,
    input  logic       DIN_VALID,
    output logic       DIN_READY,
    output logic       LINEA,
    output logic       FRAME,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR,
    output logic [7:0] CNT
);

    localparam int              AW       = $clog2(DEPTH);
    localparam int              CW       = AW + 1;
    localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [3:0]      GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    // The shift register holds the bits still to be sent after the MSB,
    // which goes straight onto LINEA at load time.
`ifdef B02_BCD_TX_PARITY_EN
    localparam int              SHW      = 4;
    localparam logic [2:0]      LAST_IDX = 3'd4;
`else
    localparam int              SHW      = 3;
    localparam logic [2:0]      LAST_IDX = 3'd3;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    // ---------------------------------------------------------------- FIFO
    logic [3:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          full, empty;
    logic          xfer, bad_digit, push, pop;
    logic [3:0]    head;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign DIN_READY = reset & ~full;
    assign xfer      = DIN_VALID & DIN_READY;
    assign bad_digit = (DIN > 4'd9);
    assign push      = xfer & ~bad_digit;
    assign head      = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Storage is not reset; occupancy is tracked by the pointers/count only.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= DIN;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // ----------------------------------------------------------------- FSM
    state_t         state_q, state_d;
    logic [SHW-1:0] sh_q, sh_d;
    logic [2:0]     idx_q, idx_d;
    logic [3:0]     gap_q, gap_d;
    logic           linea_q, linea_d;
    logic           frame_q, frame_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic [7:0]     cnt_q, cnt_d;
    logic           start;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
            linea_q <= IDLE_LVL;
            frame_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            linea_q <= linea_d;
            frame_q <= frame_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        linea_d = linea_q;
        frame_d = frame_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        err_d   = err_q | (xfer & bad_digit);
        start   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    start = 1'b1;
                end else begin
                    linea_d = IDLE_LVL;
                    frame_d = 1'b0;
                end
            end
            S_SHIFT: begin
                if (idx_q == LAST_IDX) begin
                    done_d = 1'b1;
                    cnt_d  = cnt_q + 8'd1;
                    if (GAP > 0) begin
                        linea_d = IDLE_LVL;
                        frame_d = 1'b0;
                        gap_d   = GAP_LOAD;
                        state_d = S_GAP;
                    end else if (!empty) begin
                        // back-to-back: next digit starts on this same edge
                        start = 1'b1;
                    end else begin
                        linea_d = IDLE_LVL;
                        frame_d = 1'b0;
                        state_d = S_IDLE;
                    end
                end else begin
                    linea_d = sh_q[SHW-1];
                    sh_d    = {sh_q[SHW-2:0], 1'b0};
                    idx_d   = idx_q + 3'd1;
                end
            end
            S_GAP: begin
                if (gap_q != 4'd0) begin
                    gap_d = gap_q - 4'd1;
                end else if (!empty) begin
                    start = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                linea_d = IDLE_LVL;
                frame_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        // Common digit start: pop the head, put its MSB on the line and
        // keep the remaining bits in the shift register.
        if (start) begin
            linea_d = head[3];
            frame_d = 1'b1;
            idx_d   = 3'd0;
`ifdef B02_BCD_TX_PARITY_EN
            sh_d    = {head[2:0], ~^head};
`else
            sh_d    = head[2:0];
`endif
            state_d = S_SHIFT;
        end
    end

    assign pop   = start;
    assign LINEA = linea_q;
    assign FRAME = frame_q;
    assign DONE  = done_q;
    assign ERR   = err_q;
    assign CNT   = cnt_q;
    assign BUSY  = ~empty | (state_q != S_IDLE);

endmodule
